// File: rtl/exe_pkg.sv
// Shared types for the execute stage: opcodes, condition codes, NZCV flags
// and the multiply sequencing states.
package exe_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_ORR = 4'd3,
      OP_EOR = 4'd4,
      OP_MOV = 4'd5,
      OP_MUL = 4'd6
   } alu_op_t;

   typedef enum logic [3:0] {
      C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
      C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
   } cond_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} exe_state_t;

endpackage

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, W cycles per
// product, low W bits kept. start loads operands, done flags the last step.
module mul_iter
   import exe_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] product
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  mcand;
   logic [W-1:0]  mplier;
   logic [W-1:0]  acc;
   logic [CW-1:0] count;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         count  <= '0;
         busy   <= 1'b1;
      end else if (busy) begin
         if (mplier[0])
            acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
         if (done)
            busy <= 1'b0;
      end
   end

   assign done    = busy && (count == CW'(W - 1));
   assign product = acc;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, iterative multiply with decode stall,
// ARM condition evaluation and the NZCV register feeding the M-side outputs.
module exe_stage
   import exe_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         validE,
   input  logic [W-1:0] srcAE,
   input  logic [W-1:0] srcBE,
   input  logic [W-1:0] extE,
   input  logic         aluSrcE,
   input  logic [3:0]   aluControlE,
   input  logic [1:0]   flagWriteE,
   input  logic [3:0]   condE,
   input  logic         regWriteE,
   input  logic [3:0]   WA3EIn,
   output logic         stallE,
   output logic         validM,
   output logic [W-1:0] aluResultM,
   output logic [W-1:0] writeDataM,
   output logic [3:0]   WA3M,
   output logic         regWriteM,
   output logic [3:0]   flags
);

   exe_state_t   state, state_nxt;
   flags_t       flags_q;
   alu_op_t      op;
   logic [W-1:0] op_b, alu_result, product;
   logic         alu_c, alu_v, arith, cond_ok, exec;
   logic         mul_start, mul_busy, mul_done, wr_single, wr_mul;
   logic [3:0]   lat_wa3;
   logic         lat_rw;
   logic [1:0]   lat_fw;
   logic [W-1:0] lat_srcb;

   assign op    = alu_op_t'(aluControlE);
   assign op_b  = aluSrcE ? extE : srcBE;
   assign flags = flags_q;

   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned and infers a latch.
   always_comb begin
      alu_result = '0;
      alu_c      = 1'b0;
      alu_v      = 1'b0;
      arith      = 1'b0;
      case (op)
         OP_SUB: begin
            {alu_c, alu_result} = {1'b0, srcAE} + {1'b0, ~op_b} + 1'b1;
            alu_v = (srcAE[W-1] != op_b[W-1]) && (alu_result[W-1] != srcAE[W-1]);
            arith = 1'b1;
         end
         OP_AND: alu_result = srcAE & op_b;
         OP_ORR: alu_result = srcAE | op_b;
         OP_EOR: alu_result = srcAE ^ op_b;
         OP_MOV: alu_result = op_b;
         OP_MUL: alu_result = '0;
         default: begin
            {alu_c, alu_result} = {1'b0, srcAE} + {1'b0, op_b};
            alu_v = (srcAE[W-1] == op_b[W-1]) && (alu_result[W-1] != srcAE[W-1]);
            arith = 1'b1;
         end
      endcase
   end

   always_comb begin
      cond_ok = 1'b0;
      case (cond_t'(condE))
         C_EQ: cond_ok = flags_q.z;
         C_NE: cond_ok = !flags_q.z;
         C_CS: cond_ok = flags_q.c;
         C_CC: cond_ok = !flags_q.c;
         C_MI: cond_ok = flags_q.n;
         C_PL: cond_ok = !flags_q.n;
         C_VS: cond_ok = flags_q.v;
         C_VC: cond_ok = !flags_q.v;
         C_HI: cond_ok = flags_q.c && !flags_q.z;
         C_LS: cond_ok = !flags_q.c || flags_q.z;
         C_GE: cond_ok = (flags_q.n == flags_q.v);
         C_LT: cond_ok = (flags_q.n != flags_q.v);
         C_GT: cond_ok = !flags_q.z && (flags_q.n == flags_q.v);
         C_LE: cond_ok = flags_q.z || (flags_q.n != flags_q.v);
         C_AL: cond_ok = 1'b1;
         C_NV: cond_ok = 1'b0;
      endcase
   end

   assign exec = validE && cond_ok;

   always_comb begin
      state_nxt = state;
      stallE    = 1'b0;
      mul_start = 1'b0;
      wr_single = 1'b0;
      wr_mul    = 1'b0;
      case (state)
         S_IDLE: begin
            if (exec) begin
               if (op == OP_MUL) begin
                  stallE    = 1'b1;
                  mul_start = 1'b1;
                  state_nxt = S_MUL;
               end else begin
                  wr_single = 1'b1;
               end
            end
         end
         S_MUL: begin
            stallE = 1'b1;
            if (mul_done)
               state_nxt = S_DONE;
         end
         S_DONE: begin
            wr_mul    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   mul_iter #(.W(W)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (srcAE),
      .b       (op_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (product)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         lat_wa3  <= '0;
         lat_rw   <= 1'b0;
         lat_fw   <= '0;
         lat_srcb <= '0;
      end else begin
         state <= state_nxt;
         if (mul_start) begin
            lat_wa3  <= WA3EIn;
            lat_rw   <= regWriteE;
            lat_fw   <= flagWriteE;
            lat_srcb <= srcBE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         validM     <= 1'b0;
         aluResultM <= '0;
         writeDataM <= '0;
         WA3M       <= '0;
         regWriteM  <= 1'b0;
         flags_q    <= '0;
      end else if (wr_single) begin
         validM     <= 1'b1;
         aluResultM <= alu_result;
         writeDataM <= srcBE;
         WA3M       <= WA3EIn;
         regWriteM  <= regWriteE;
         if (flagWriteE[1]) begin
            flags_q.n <= alu_result[W-1];
            flags_q.z <= (alu_result == '0);
         end
         // Logic, MOV and MUL keep C,V even when the C,V enable is set.
         if (flagWriteE[0] && arith) begin
            flags_q.c <= alu_c;
            flags_q.v <= alu_v;
         end
      end else if (wr_mul) begin
         validM     <= 1'b1;
         aluResultM <= product;
         writeDataM <= lat_srcb;
         WA3M       <= lat_wa3;
         regWriteM  <= lat_rw;
         if (lat_fw[1]) begin
            flags_q.n <= product[W-1];
            flags_q.z <= (product == '0);
         end
      end else begin
         validM    <= 1'b0;
         regWriteM <= 1'b0;
      end
   end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the pipelined ARM core: consumes the operands, extended immediate and destination register index latched by the decode/execute pipeline register and produces the registered execute/memory-side result. Performs single-cycle ALU operations, an iterative 32-cycle multiply with a stall back to decode, ARM condition-code evaluation and the NZCV flags register.

## Interface
- `W`, 32: datapath width.
- `clk`  in  1: core clock, all state updates on posedge.
- `rst`  in  1: asynchronous, active-low reset.
- `validE`  in  1: execute-side instruction present.
- `srcAE`  in  W: register operand A.
- `srcBE`  in  W: register operand B; also store data.
- `extE`  in  W: extended immediate.
- `aluSrcE`  in  1: 1 selects `extE` as operand B, 0 selects `srcBE`.
- `aluControlE`  in  4: ALU operation code.
- `flagWriteE`  in  2: bit1 enables N,Z update; bit0 enables C,V update.
- `condE`  in  4: ARM condition field.
- `regWriteE`  in  1: instruction writes a register.
- `WA3EIn`  in  4: destination register index.
- `stallE`  out  1: combinational; upstream must hold all E inputs while high.
- `validM`  out  1: registered; result below is a real instruction.
- `aluResultM`  out  W: registered ALU/multiply result.
- `writeDataM`  out  W: registered `srcBE`.
- `WA3M`  out  4: registered destination index.
- `regWriteM`  out  1: registered, forced 0 when `validM`=0.
- `flags`  out  4: current NZCV register {N,Z,C,V}.

## Operation
- Operand B = `aluSrcE ? extE : srcBE`.
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 ORR, 4 EOR, 5 MOV (B), 6 MUL (low W bits of A·B); 7–15 behave as ADD.
- Condition check against current `flags`: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); 14 AL true; 15 false.
- Instruction executes only when `validE` and condition true; otherwise it is a bubble: `validM`=0, `regWriteM`=0, flags unchanged.
- Flags on executed instruction: N = result[W−1], Z = result==0; ADD: C = carry out, V = signed overflow; SUB: C = no-borrow (A≥B unsigned), V = signed overflow; logic/MOV/MUL: C,V retained even if bit0 set.
- FSM states IDLE, MUL, DONE. Multiplier is radix-2 shift-add, one multiplier bit per cycle, 5-bit counter.
  - IDLE: executing MUL → `stallE`=1, latch A,B, WA3, regWrite, flagWrite, go MUL with count=0. Any other op completes this cycle.
  - MUL: `stallE`=1, `validM`=0 each edge; count==31 → DONE.
  - DONE: `stallE`=0; on edge, product written to M outputs with `validM`=1, flags updated, → IDLE.
- MUL whose condition fails is a bubble and never leaves IDLE.

## Timing
- Single-cycle ops: result on M outputs one edge after presentation; no stall.
- MUL presented in cycle 0: `stallE` high cycles 0–32, low cycle 33; `validM`=1 with product after edge 33 (34 cycles).
- `validM`=0 in every cycle of a multiply before completion.
- Flags update on the same edge that writes the result; the next instruction sees new flags.
- Reset (any time, including mid-multiply): state IDLE, counter 0, flags 0000, `validM`=0, `regWriteM`=0, `aluResultM`/`writeDataM`=0, `WA3M`=0, `stallE`=0 after reset; partial product discarded.
- Inputs changing while `stallE`=1 are a protocol violation; latched copies are used.

## Structure
- Package `exe_pkg`: `alu_op_t` enum, `cond_t` enum, `flags_t` packed struct {n,z,c,v}, `exe_state_t` enum, width constant.
- Sub-module `mul_iter`: start/busy/done handshake, 32-cycle shift-add, W-bit low product. Condition check and ALU stay in `exe_stage`.

## Test plan
- Reset then ADD A=0x7FFFFFFF, B=1, flagWrite=11, AL → after 1 edge `aluResultM`=0x80000000, `validM`=1, flags N=1 Z=0 C=0 V=1.
- SUB imm: A=5, ext=5, aluSrc=1, flagWrite=11 → result 0, flags Z=1 C=1; following instruction cond=EQ executes, cond=NE yields `validM`=0, `regWriteM`=0.
- MUL A=0x00012345, B=0x00000100, WA3=7 → `stallE` high 33 cycles, `validM`=1 on cycle 34 with 0x01234500, `WA3M`=7.
- MUL A=0xFFFFFFFF, B=0xFFFFFFFF, flagWrite=10 → result 0x00000001, N=0 Z=0, C/V unchanged from prior value.
- Assert `rst` low during cycle 15 of a multiply → `stallE`=0, flags 0000, `validM`=0; subsequent ADD 2+3 produces 5 one edge later.
- cond=15 with validE=1, regWrite=1 → `validM`=0, `regWriteM`=0, flags unchanged.
